// File: rtl/tape_input.sv
// Cassette input front end: synchronises and deglitches the squared tape signal,
// then times the gap between accepted edges and hands each result to the CPU.
`timescale 1ns/1ps
module tape_input #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT     = 4000,
    parameter int THRESHOLD   = 900
) (
    input  logic                 clk_cpu,
    input  logic                 rst_n,
    input  logic                 tape_in,
    input  logic                 ack,
    output logic                 tape_level,
    output logic                 edge_stb,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 tape_bit,
    output logic                 ready,
    output logic                 overrun,
    output logic                 timeout,
    output logic                 active
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0]        LP_FMAX    = FW'(FILT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] LP_THRESH  = CNT_WIDTH'(THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_edge_stb;
    logic [FW-1:0]          r_fcnt;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_next;

    logic [CNT_WIDTH-1:0]   r_half_period;
    logic                   r_tape_bit;
    logic                   r_ready;
    logic                   r_overrun;
    logic                   r_timeout;

    logic                   w_s;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_timeout_evt;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_s != r_level) && (r_fcnt == LP_FMAX);

    // Level only flips after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_level    <= 1'b0;
            r_edge_stb <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], tape_in};
            r_edge_stb <= w_accept;
            if (w_s == r_level) begin
                r_fcnt <= '0;
            end else if (w_accept) begin
                r_fcnt  <= '0;
                r_level <= ~r_level;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // cnt restarts at 1 on an edge so the captured value equals the edge-to-edge clock count.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_state_next = S_MEASURE;
                    w_cnt_next   = LP_ONE;
                end
            end
            S_MEASURE: begin
                if (w_accept) begin
                    w_capture  = 1'b1;
                    w_cnt_next = LP_ONE;
                end else if (r_cnt == LP_TIMEOUT) begin
                    w_timeout_evt = 1'b1;
                    w_state_next  = S_IDLE;
                    w_cnt_next    = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // A fresh capture keeps ready high even when ack arrives in the same cycle.
    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            r_half_period <= '0;
            r_tape_bit    <= 1'b0;
            r_ready       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_half_period <= r_cnt;
                r_tape_bit    <= (r_cnt > LP_THRESH);
            end
            r_ready   <= w_capture | (r_ready & ~ack);
            r_overrun <= ~ack & (r_overrun | (w_capture & r_ready));
            r_timeout <= w_timeout_evt | (r_timeout & ~ack);
        end
    end

    assign tape_level  = r_level;
    assign edge_stb    = r_edge_stb;
    assign half_period = r_half_period;
    assign tape_bit    = r_tape_bit;
    assign ready       = r_ready;
    assign overrun     = r_overrun;
    assign timeout     = r_timeout;
    assign active      = (r_state == S_MEASURE);

endmodule

// File: tb/tb_tape_input.sv
// Bench for tape_input: directed glitch/timeout/handshake sequences, a vector table
// of half-periods, and a randomized square wave checked against an interval model.
`timescale 1ns/1ps
module tb_tape_input;

    localparam int CW        = 16;
    localparam int TIMEOUT   = 4000;
    localparam int THRESHOLD = 900;
    localparam int NV        = 9;

    logic          clk_cpu = 1'b0;
    logic          rst_n   = 1'b0;
    logic          tape_in = 1'b0;
    logic          ack_d   = 1'b0;
    logic          ack_m   = 1'b0;
    logic          ack;
    logic          tape_level;
    logic          edge_stb;
    logic [CW-1:0] half_period;
    logic          tape_bit;
    logic          ready;
    logic          overrun;
    logic          timeout;
    logic          active;

    assign ack = ack_d | ack_m;

    tape_input #(
        .SYNC_STAGES(2),
        .FILT_LEN   (8),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TIMEOUT),
        .THRESHOLD  (THRESHOLD)
    ) dut (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .tape_in    (tape_in),
        .ack        (ack),
        .tape_level (tape_level),
        .edge_stb   (edge_stb),
        .half_period(half_period),
        .tape_bit   (tape_bit),
        .ready      (ready),
        .overrun    (overrun),
        .timeout    (timeout),
        .active     (active)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_cpu);
    endtask

    task automatic pulse_ack();
        ack_d = 1'b1;
        @(negedge clk_cpu);
        ack_d = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   tape_level,  0);
        check({tag, "_stb"},     edge_stb,    0);
        check({tag, "_hp"},      half_period, 0);
        check({tag, "_bit"},     tape_bit,    0);
        check({tag, "_ready"},   ready,       0);
        check({tag, "_overrun"}, overrun,     0);
        check({tag, "_timeout"}, timeout,     0);
        check({tag, "_active"},  active,      0);
    endtask

    // Scoreboard for the random phase: {tape_bit, half_period} per expected result.
    logic [CW:0] exp_q[$];
    logic [CW:0] mon_e;
    int          exp_to = 0;
    int          obs_to = 0;
    logic        mon_en = 1'b0;

    always @(negedge clk_cpu) begin
        if (!mon_en) begin
            ack_m = 1'b0;
        end else if (ack_m) begin
            ack_m = 1'b0;
        end else if (ready || timeout) begin
            if (timeout) obs_to++;
            if (ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rand_extra: got result %0d expected none", half_period);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rand_hp",  half_period, 32'(mon_e[CW-1:0]));
                    check("rand_bit", tape_bit,    32'(mon_e[CW]));
                end
            end
            check("rand_overrun", overrun, 0);
            ack_m = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int   gap;
        logic exp_ready;
        int   exp_hp;
        logic exp_bit;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        int   nstb, nlev, first_hi, first_stb, used, r, p, prev;
        logic in_meas;

        vecs[0] = '{20,   1'b0, 0,    1'b0};
        vecs[1] = '{1198, 1'b1, 1198, 1'b1};
        vecs[2] = '{1198, 1'b1, 1198, 1'b1};
        vecs[3] = '{1198, 1'b1, 1198, 1'b1};
        vecs[4] = '{599,  1'b1, 599,  1'b0};
        vecs[5] = '{900,  1'b1, 900,  1'b0};
        vecs[6] = '{901,  1'b1, 901,  1'b1};
        vecs[7] = '{4000, 1'b1, 4000, 1'b1};
        vecs[8] = '{14,   1'b1, 14,   1'b0};

        // Reset hold and release
        rst_n = 1'b0;
        tape_in = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(3);
        check_all_zero("rst");

        // 7-cycle pulse must be rejected
        tape_in = 1'b1;
        nstb = 0;
        nlev = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk_cpu);
            if (edge_stb) nstb++;
            if (tape_level) nlev++;
            if (i == 7) tape_in = 1'b0;
        end
        check("glitch_stb", nstb, 0);
        check("glitch_level", nlev, 0);

        // 8-cycle pulse: accepted 10 cycles after each tape_in change
        tape_in = 1'b1;
        nstb = 0;
        first_hi = 0;
        first_stb = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_cpu);
            if (edge_stb) nstb++;
            if (edge_stb && first_stb == 0) first_stb = i;
            if (tape_level && first_hi == 0) first_hi = i;
            if (i == 8) tape_in = 1'b0;
        end
        check("pulse_level_lat", first_hi, 10);
        check("pulse_stb_lat", first_stb, 10);
        check("pulse_stb_count", nstb, 2);
        check("pulse_level_end", tape_level, 0);
        check("pulse_ready", ready, 1);
        check("pulse_hp", half_period, 8);
        check("pulse_bit", tape_bit, 0);

        // Silence: timeout exactly 4000 cycles after the last captured edge
        tick(3987);
        check("to_before_flag", timeout, 0);
        check("to_before_active", active, 1);
        tick(1);
        check("to_flag", timeout, 1);
        check("to_active", active, 0);
        check("to_ready_held", ready, 1);
        check("to_overrun", overrun, 0);
        pulse_ack();
        tick(1);
        check("to_ack_flag", timeout, 0);
        check("to_ack_ready", ready, 0);
        check("to_hp_held", half_period, 8);

        // After timeout: first edge yields nothing, next edge a valid result
        tape_in = 1'b1;
        tick(12);
        check("post_to_ready", ready, 0);
        check("post_to_active", active, 1);
        tick(488);
        tape_in = 1'b0;
        tick(12);
        check("post_to_ready2", ready, 1);
        check("post_to_hp", half_period, 500);
        check("post_to_bit", tape_bit, 0);
        pulse_ack();
        tick(1);

        // Reset in the middle of a measurement
        check("pre_reset_active", active, 1);
        rst_n = 1'b0;
        tape_in = 1'b0;
        tick(1);
        check_all_zero("mid_rst");
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Vector table of half-periods
        used = 0;
        for (int i = 0; i < NV; i++) begin
            tick(vecs[i].gap - used);
            tape_in = ~tape_in;
            tick(12);
            check($sformatf("vec%0d_ready", i), ready, 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready) begin
                check($sformatf("vec%0d_hp", i), half_period, vecs[i].exp_hp);
                check($sformatf("vec%0d_bit", i), tape_bit, 32'(vecs[i].exp_bit));
            end
            check($sformatf("vec%0d_overrun", i), overrun, 0);
            pulse_ack();
            tick(1);
            check($sformatf("vec%0d_ack_ready", i), ready, 0);
            used = 14;
        end

        // Overrun: two captures with no ack in between
        tick(100 - used);
        tape_in = ~tape_in;
        tick(150);
        tape_in = ~tape_in;
        tick(12);
        check("ovr_ready", ready, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_hp", half_period, 150);
        check("ovr_bit", tape_bit, 0);
        pulse_ack();
        tick(1);
        check("ovr_ack_flag", overrun, 0);
        check("ovr_ack_ready", ready, 0);

        // Capture coincident with ack while an older result is unread
        tick(200 - 14);
        tape_in = ~tape_in;
        tick(300);
        tape_in = ~tape_in;
        tick(9);
        check("coinc_pre_ready", ready, 1);
        ack_d = 1'b1;
        tick(1);
        ack_d = 1'b0;
        check("coinc_ready", ready, 1);
        check("coinc_overrun", overrun, 0);
        check("coinc_hp", half_period, 300);
        pulse_ack();
        tick(1);

        // Randomized square wave against the interval model
        rst_n = 1'b0;
        tape_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        mon_en = 1'b1;
        in_meas = 1'b0;
        prev = 0;
        for (int k = 0; k < 20; k++) begin
            tape_in = ~tape_in;
            if (in_meas) begin
                if (prev <= TIMEOUT)
                    exp_q.push_back({(prev > THRESHOLD) ? 1'b1 : 1'b0, CW'(prev)});
                else
                    exp_to++;
            end
            in_meas = 1'b1;
            r = $urandom_range(0, 9);
            if (r == 0)      p = $urandom_range(3990, 4200);
            else if (r == 1) p = $urandom_range(895, 905);
            else             p = $urandom_range(12, 1500);
            prev = p;
            tick(p);
        end
        tick(TIMEOUT + 50);
        exp_to++;
        tick(5);
        mon_en = 1'b0;
        check("rand_left", exp_q.size(), 0);
        check("rand_timeouts", obs_to, exp_to);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tape_input.md
Name: tape_input

Overview:
Cassette input front end for the tape interface. It samples the comparator-squared tape signal and filters out short glitches. It measures the time between accepted edges and presents each half-period to the CPU with a ready/ack handshake, plus a short/long bit classification. It sits beside the tape output path on clk_cpu and feeds the CPU I/O port decode.

Parameters:
SYNC_STAGES, 2, synchroniser flops on tape_in (min 2)
FILT_LEN, 8, consecutive differing samples required to accept a level change (min 1)
CNT_WIDTH, 16, width of half-period counter and result
TIMEOUT, 4000, cycles without an edge before returning to IDLE (< 2^CNT_WIDTH)
THRESHOLD, 900, half-periods strictly greater than this classify as long (bit 1)

Ports:
clk_cpu  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk_cpu
tape_in  in  1  asynchronous squared tape signal
ack  in  1  CPU read strobe, one cycle, consumes current result
tape_level  out  1  filtered tape level
edge_stb  out  1  one-cycle pulse when tape_level toggles
half_period  out  CNT_WIDTH  cycles between the last two accepted edges
tape_bit  out  1  1 if half_period > THRESHOLD, else 0
ready  out  1  a half_period result is unread
overrun  out  1  sticky: a result was overwritten while unread
timeout  out  1  sticky: carrier lost (TIMEOUT reached in MEASURE)
active  out  1  state == MEASURE

Behaviour:
- Reset (rst_n=0 at a clock edge): sync chain, tape_level, filter count, counter, half_period and all flags go to 0; state goes to IDLE. This applies identically mid-measurement.
- Synchroniser: tape_in passes through SYNC_STAGES flops. s is the last stage.
- Filter: fcnt increments on each cycle where s != tape_level and resets to 0 on any cycle where s == tape_level.
  - When s != tape_level and fcnt == FILT_LEN-1, tape_level toggles, edge_stb=1 for that cycle, and fcnt is set to 0.
  - A pulse shorter than FILT_LEN cycles at s is rejected.
  - Total latency from a tape_in change to the tape_level change is SYNC_STAGES+FILT_LEN cycles.
- State IDLE:
  - cnt is held at 0.
  - On an accepted edge: go to MEASURE with cnt<=1. No result is produced, because there is no prior edge.
- State MEASURE:
  - With no edge: cnt<=cnt+1.
  - On an accepted edge: half_period<=cnt, tape_bit<=(cnt>THRESHOLD), ready<=1, cnt<=1, stay in MEASURE.
  - If cnt == TIMEOUT with no edge that cycle: timeout<=1, go to IDLE, cnt<=0. An edge in the same cycle takes priority (capture, no timeout).
- half_period equals the exact clock count between the two edge_stb pulses.
- Handshake:
  - ack clears ready, overrun and timeout on the next edge.
  - A capture with ready=1 and no ack sets overrun; the new value overwrites the old.
  - A capture and ack in the same cycle: ready stays 1, overrun is not set, and the new value is loaded.
  - ack with ready=0 has no effect beyond clearing the sticky flags.
- half_period and tape_bit hold their value until the next capture; ack does not clear them.
- All outputs are registered. No combinational path from tape_in or ack to any output.

Test Plan:
- Reset hold, then release with tape_in=0 → all outputs 0, active=0. Assert rst_n=0 during MEASURE → all outputs return to 0 the next cycle and state is IDLE.
- Glitch rejection: tape_in high for 7 cycles, then low → no edge_stb, tape_level stays 0. High for 8 cycles → tape_level=1 exactly 10 cycles after the rising edge, edge_stb one cycle.
- Square wave with 1198-cycle half-period, 4 edges → first edge gives no ready; next 3 captures give half_period=1198, tape_bit=1. ack after each → ready toggles 1→0, overrun=0.
- 599-cycle half-period → half_period=599, tape_bit=0. THRESHOLD boundary: 900 → bit 0, 901 → bit 1.
- Overrun: two captures without ack → overrun=1, half_period=second value. Capture coincident with ack → ready=1, overrun=0.
- Timeout: one edge then silence → timeout=1 at cnt=4000, state IDLE, active=0. Next edge produces no result; the following edge produces a valid half_period.
